// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Sequential 32-bit shifter/rotator; one bit position per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] num_shifts,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_OP_SHR  = 3'b000;
    localparam logic [2:0] c_OP_SHRA = 3'b001;
    localparam logic [2:0] c_OP_SHL  = 3'b010;
    localparam logic [2:0] c_OP_ROR  = 3'b011;
    localparam logic [2:0] c_OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [31:0] r_work_q,  w_work_d;
    logic [5:0]  r_count_q, w_count_d;
    logic [2:0]  r_op_q,    w_op_d;

    logic [5:0]  w_load_count;
    logic [31:0] w_step;

    // Shift amounts saturate at 32 (the operand is fully flushed);
    // rotates only care about the amount modulo 32.
    always_comb begin
        w_load_count = 6'd0;
        case (op)
            c_OP_SHR, c_OP_SHRA, c_OP_SHL:
                w_load_count = (num_shifts > 32'd32) ? 6'd32 : num_shifts[5:0];
            c_OP_ROR, c_OP_ROL:
                w_load_count = {1'b0, num_shifts[4:0]};
            default:
                w_load_count = 6'd0;
        endcase
    end

    always_comb begin
        w_step = r_work_q;
        case (r_op_q)
            c_OP_SHR:  w_step = {1'b0, r_work_q[31:1]};
            c_OP_SHRA: w_step = {r_work_q[31], r_work_q[31:1]};
            c_OP_SHL:  w_step = {r_work_q[30:0], 1'b0};
            c_OP_ROR:  w_step = {r_work_q[0], r_work_q[31:1]};
            c_OP_ROL:  w_step = {r_work_q[30:0], r_work_q[31]};
            default:   w_step = r_work_q;
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_work_d  = r_work_q;
        w_count_d = r_count_q;
        w_op_d    = r_op_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_work_d  = in_a;
                    w_op_d    = op;
                    w_count_d = w_load_count;
                    w_state_d = (w_load_count == 6'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_work_d  = w_step;
                w_count_d = r_count_q - 6'd1;
                if (r_count_q == 6'd1) begin
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state_q <= S_IDLE;
            r_work_q  <= 32'd0;
            r_count_q <= 6'd0;
            r_op_q    <= 3'd0;
        end else begin
            r_state_q <= w_state_d;
            r_work_q  <= w_work_d;
            r_count_q <= w_count_d;
            r_op_q    <= w_op_d;
        end
    end

    assign result = r_work_q;
    assign busy   = (r_state_q != S_IDLE);
    assign done   = (r_state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Scoreboard bench for shift_seq_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_a;
    logic [31:0] num_shifts;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    shift_seq_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .op         (op),
        .in_a       (in_a),
        .num_shifts (num_shifts),
        .result     (result),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input int c, input string nm);
        exp_t e;
        e.res  = res;
        e.cyc  = c;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] n,
                         input logic [31:0] exp_res, input int cnt, input string nm);
        int busy_n;
        bit seen;
        @(negedge clk);
        op = o; in_a = a; num_shifts = n; start = 1'b1;
        push_exp(exp_res, cyc + 1 + cnt, nm);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            in_a  = ~a;
            op    = 3'b111;
            num_shifts = 32'd7;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_busy_cycles"}, busy_n, cnt + 1);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && busy === 1'b0) ok = 1'b1;
        end
        chk({nm, "_drained"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int k;
        clr = 1'b1; start = 1'b0; op = 3'd0; in_a = 32'd0; num_shifts = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_busy",   32'(busy), 32'd0);
        chk("reset_done",   32'(done), 32'd0);
        clr = 1'b0;

        do_op(3'b011, 32'h0000_00F1, 32'd4,         32'h1000_000F, 4,  "ror4");
        do_op(3'b011, 32'h0000_00F1, 32'd36,        32'h1000_000F, 4,  "ror36");
        do_op(3'b001, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 32, "shra40");
        do_op(3'b000, 32'h8000_0000, 32'd40,        32'h0000_0000, 32, "shr40");
        do_op(3'b010, 32'h1234_5678, 32'd0,         32'h1234_5678, 0,  "shl0");
        do_op(3'b100, 32'h8000_0001, 32'd1,         32'h0000_0003, 1,  "rol1");
        do_op(3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32, "shl_max");
        do_op(3'b000, 32'hF000_0000, 32'd4,         32'h0F00_0000, 4,  "shr4");
        do_op(3'b001, 32'hF000_0000, 32'd4,         32'hFF00_0000, 4,  "shra4");
        do_op(3'b010, 32'h0000_000F, 32'd4,         32'h0000_00F0, 4,  "shl4");
        do_op(3'b101, 32'hDEAD_BEEF, 32'd5,         32'hDEAD_BEEF, 0,  "pass");
        do_op(3'b000, 32'hA5A5_A5A5, 32'd33,        32'h0000_0000, 32, "shr33");

        // Restart during SHIFT is ignored; the original operands carry through
        @(negedge clk);
        op = 3'b011; in_a = 32'h0000_00F1; num_shifts = 32'd8; start = 1'b1;
        push_exp(32'hF100_0000, cyc + 9, "ror8_restart");
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; in_a = 32'hFFFF_FFFF; op = 3'b010; num_shifts = 32'd3;
        @(negedge clk); start = 1'b0;
        wait_idle("ror8_restart");

        // Abort mid-SHIFT: no done pulse may follow
        @(negedge clk);
        op = 3'b011; in_a = 32'h0000_00F1; num_shifts = 32'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("abort_busy",   32'(busy), 32'd0);
        chk("abort_done",   32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        // clr and start together: clr wins
        clr = 1'b1; start = 1'b1; op = 3'b011; in_a = 32'h0000_0005; num_shifts = 32'd3;
        @(negedge clk); clr = 1'b0; start = 1'b0;
        chk("clr_start_busy",   32'(busy), 32'd0);
        chk("clr_start_result", result, 32'd0);
        repeat (5) @(negedge clk);
        chk("clr_start_idle", 32'(busy), 32'd0);

        // Back-to-back with start held high: period is count+2
        @(negedge clk);
        k = cyc + 1;
        op = 3'b100; in_a = 32'h8000_0001; num_shifts = 32'd1; start = 1'b1;
        push_exp(32'h0000_0003, k + 1, "b2b_rol1");
        @(negedge clk);
        op = 3'b000; in_a = 32'h0000_0100; num_shifts = 32'd8;
        push_exp(32'h0000_0001, k + 1 + 2 + 8, "b2b_shr8");
        for (int i = 0; i < 10 && cyc < k + 3; i++) @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001: The block SHALL have no parameters; datapath width SHALL be fixed at 32 bits.
REQ-002: The block SHALL use one clock and a synchronous, active-high reset.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: clr  input  1  synchronous active-high reset.
REQ-005: start  input  1  request a new operation; sampled only in IDLE.
REQ-006: op  input  3  operation code: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 pass-through.
REQ-007: in_a  input  32  operand, captured at start.
REQ-008: num_shifts  input  32  shift/rotate amount, captured at start.
REQ-009: result  output  32  registered result; holds its value until the next accepted start or clr.
REQ-010: busy  output  1  high in every state except IDLE.
REQ-011: done  output  1  one-cycle pulse; result is valid while done is high.

Function
REQ-012: The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013: In IDLE with start=1 at edge E0, the block SHALL load in_a into the work register (driven on result) and load the 6-bit count.
- ROR/ROL: count = num_shifts[4:0].
- SHR/SHRA/SHL: count = min(num_shifts, 32).
- Pass-through codes: count = 0.
REQ-014: At E0 the next state SHALL be DONE if count=0, else SHIFT.
REQ-015: Each edge in SHIFT SHALL apply one 1-bit step and decrement count.
- SHR: zero fill at bit 31.
- SHRA: bit 31 replicated.
- SHL: zero fill at bit 0.
- ROR: bit 0 moves to bit 31.
- ROL: bit 31 moves to bit 0.
REQ-016: The SHIFT edge on which count goes from 1 to 0 SHALL transition to DONE.
REQ-017: done SHALL be high exactly in the cycle following edge E(count), i.e. latency = count edges after the start edge (0 for count=0); maximum latency is 32.
REQ-018: DONE SHALL return to IDLE on the next edge unconditionally.
REQ-019: start SHALL be ignored in SHIFT and DONE; the earliest accepted restart is the cycle after DONE.
REQ-020: in_a, num_shifts and op changes after E0 SHALL NOT affect the operation in progress.
REQ-021: Back-to-back operation SHALL be supported: start held high continuously yields one operation per (count+2) cycles.
REQ-022: num_shifts bits [31:6] SHALL be honoured for shift saturation; a value of 0xFFFF_FFFF SHALL count as 32.

Reset
REQ-023: When clr=1 at an edge, the block SHALL force state=IDLE, result=0, count=0, busy=0 and done=0 on the following cycle, regardless of state or start.
REQ-024: clr asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-025: If clr and start are both high, clr SHALL win and start SHALL be ignored.

Verification
REQ-026: ROR in_a=0x0000_00F1, num_shifts=4 -> result=0x1000_000F; done high 4 edges after the start edge; busy high for 5 cycles.
REQ-027: ROR in_a=0x0000_00F1, num_shifts=36 -> same result and timing as num_shifts=4.
REQ-028: SHRA in_a=0x8000_0000, num_shifts=40 -> result=0xFFFF_FFFF after 32 shift edges; SHR with the same inputs -> 0x0000_0000.
REQ-029: SHL in_a=0x1234_5678, num_shifts=0 -> done in the cycle after the start edge with result=0x1234_5678; ROL in_a=0x8000_0001, num_shifts=1 -> 0x0000_0003.
REQ-030: Start ROR by 8 and pulse start again at cycle 3 with different in_a -> second start is ignored and the first result is correct. Assert clr at cycle 5 -> next cycle busy=0, done=0, result=0, and no done pulse follows.
